// File: rtl/frog_pkg.sv
// Shared types for the frog move path: direction codes, key indices and the
// move-generator FSM states, plus small helpers for direction encoding.
package frog_pkg;

    typedef enum logic [2:0] {DIR_NONE, DIR_RIGHT, DIR_UP, DIR_DOWN, DIR_LEFT} dir_t;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT} mg_state_t;

    localparam int KEY_RIGHT = 0;
    localparam int KEY_UP    = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_LEFT  = 3;
    localparam int NUM_KEYS  = 4;

    // Fixed priority Right > Up > Down > Left, matching the tracker.
    function automatic dir_t pick_dir(input logic [3:0] rise);
        dir_t d;
        d = DIR_NONE;
        if (rise[KEY_RIGHT])     d = DIR_RIGHT;
        else if (rise[KEY_UP])   d = DIR_UP;
        else if (rise[KEY_DOWN]) d = DIR_DOWN;
        else if (rise[KEY_LEFT]) d = DIR_LEFT;
        return d;
    endfunction

    function automatic logic [3:0] dir_onehot(input dir_t d);
        logic [3:0] v;
        v = '0;
        case (d)
            DIR_RIGHT: v[KEY_RIGHT] = 1'b1;
            DIR_UP:    v[KEY_UP]    = 1'b1;
            DIR_DOWN:  v[KEY_DOWN]  = 1'b1;
            DIR_LEFT:  v[KEY_LEFT]  = 1'b1;
            default:   v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] dir_key(input dir_t d);
        logic [2:0] t;
        t = d - 3'd1;
        return t[1:0];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button conditioner: active-low raw key -> two-flop synchroniser ->
// counter debounce. Exposes the synchronised sample and the debounced level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic synced,
    output logic stable
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= ~key_n;
            sync2_reg <= sync1_reg;
            if (sync2_reg != stable_reg) begin
                if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_reg <= sync2_reg;
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign synced = sync2_reg;
    assign stable = stable_reg;

endmodule

// File: rtl/frog_move_generator.sv
// Turns four raw push-buttons into single-cycle, mutually exclusive move pulses
// with press-edge detection, priority arbitration and hold-to-auto-repeat.
module frog_move_generator
    import frog_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       enable,
    output logic       Right,
    output logic       Up,
    output logic       Down,
    output logic       Left,
    output logic [7:0] move_count
);

    localparam int RPT_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W     = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);
    localparam int HOLD_LAST = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
    localparam int RATE_LAST = (REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0;

    logic [NUM_KEYS-1:0] synced;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] stable_d_reg;
    logic [NUM_KEYS-1:0] armed_reg;
    logic [NUM_KEYS-1:0] rise_reg;
    logic [1:0]          warm_reg;

    mg_state_t           state_reg, state_next;
    dir_t                dir_reg, dir_next;
    logic [RPT_W-1:0]    rpt_reg, rpt_next;
    logic                issue;
    logic [NUM_KEYS-1:0] pulse_reg, pulse_next;
    logic [7:0]          move_count_reg;
    logic                held;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .key_n  (key_n[gi]),
            .synced (synced[gi]),
            .stable (stable[gi])
        );
    end

    // A key only arms once the synchroniser has filled and shows it released,
    // so a button held through reset never produces a press edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_reg     <= 2'd0;
            armed_reg    <= '0;
            stable_d_reg <= '0;
            rise_reg     <= '0;
        end else begin
            if (warm_reg != 2'd2) warm_reg <= warm_reg + 2'd1;
            armed_reg    <= armed_reg | ({NUM_KEYS{warm_reg == 2'd2}} & ~synced);
            stable_d_reg <= stable;
            rise_reg     <= stable & ~stable_d_reg & armed_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            dir_reg        <= DIR_NONE;
            rpt_reg        <= '0;
            pulse_reg      <= '0;
            move_count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            rpt_reg   <= rpt_next;
            pulse_reg <= pulse_next;
            if (|pulse_reg) move_count_reg <= move_count_reg + 8'd1;
        end
    end

    assign held = stable[dir_key(dir_reg)];

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        rpt_next   = rpt_reg;
        issue      = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            dir_next   = DIR_NONE;
            rpt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|rise_reg) begin
                        dir_next   = pick_dir(rise_reg);
                        issue      = 1'b1;
                        rpt_next   = '0;
                        state_next = (REPEAT_DELAY > 0) ? HOLD : WAIT;
                    end
                end
                HOLD: begin
                    if (!held) begin
                        state_next = IDLE;
                        rpt_next   = '0;
                    end else if (rpt_reg == RPT_W'(HOLD_LAST)) begin
                        issue      = 1'b1;
                        rpt_next   = '0;
                        state_next = REPEAT;
                    end else begin
                        rpt_next = rpt_reg + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!held) begin
                        state_next = IDLE;
                        rpt_next   = '0;
                    end else if (rpt_reg == RPT_W'(RATE_LAST)) begin
                        issue    = 1'b1;
                        rpt_next = '0;
                    end else begin
                        rpt_next = rpt_reg + 1'b1;
                    end
                end
                WAIT: begin
                    if (!held) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        pulse_next = issue ? dir_onehot(dir_next) : '0;
    end

    assign Right      = pulse_reg[KEY_RIGHT];
    assign Up         = pulse_reg[KEY_UP];
    assign Down       = pulse_reg[KEY_DOWN];
    assign Left       = pulse_reg[KEY_LEFT];
    assign move_count = move_count_reg;

endmodule

// File: tb/tb_frog_move_generator.sv
// Directed bench for frog_move_generator: reset, latency/repeat timing, glitch
// rejection, arbitration, enable gating and move_count wrap.
module tb_frog_move_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic       enable;
    logic       Right, Up, Down, Left;
    logic [7:0] move_count;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int p0;

    frog_move_generator #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_RATE    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .enable     (enable),
        .Right      (Right),
        .Up         (Up),
        .Down       (Down),
        .Left       (Left),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs sampled 1ns later, exclusivity checked every cycle.
    task automatic step();
        @(posedge clk);
        #1;
        checks++;
        assert ($countones({Right, Up, Down, Left}) <= 1)
        else begin
            failures++;
            $error("FAIL onehot observed=%b expected=at_most_one_high", {Right, Up, Down, Left});
        end
        pulses += $countones({Right, Up, Down, Left});
    endtask

    initial begin
        reset  = 1'b1;
        key_n  = 4'hF;
        enable = 1'b1;
        #1;
        check("reset_outputs", {28'd0, Right, Up, Down, Left}, 32'd0);
        check("reset_count", move_count, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Idle with keys released
        p0 = pulses;
        repeat (50) step();
        check("idle_pulses", pulses - p0, 32'd0);
        check("idle_count", move_count, 32'd0);

        // Up held edges 0..19: pulses at 7,15,18,21,24, none after release
        key_n = 4'b1101;
        for (int e = 0; e <= 40; e++) begin
            if (e == 20) key_n = 4'hF;
            step();
            check($sformatf("t2_up_e%0d", e), Up, (e == 7 || e == 15 || e == 18 || e == 21 || e == 24));
            check($sformatf("t2_other_e%0d", e), {Right, Down, Left}, 32'd0);
        end
        check("t2_count", move_count, 32'd5);

        // Three-cycle glitch on Right
        p0 = pulses;
        key_n = 4'b1110;
        repeat (3) step();
        key_n = 4'hF;
        repeat (20) step();
        check("t3_pulses", pulses - p0, 32'd0);
        check("t3_count", move_count, 32'd5);

        // Right and Left together: Right wins, Left's edge is lost
        key_n = 4'b0110;
        for (int e = 0; e <= 30; e++) begin
            if (e == 6) key_n = 4'hF;
            step();
            check($sformatf("t4_right_e%0d", e), Right, (e == 7));
            check($sformatf("t4_left_e%0d", e), Left, 32'd0);
        end
        key_n = 4'b0111;
        for (int e = 0; e <= 20; e++) begin
            if (e == 8) key_n = 4'hF;
            step();
            check($sformatf("t4_left2_e%0d", e), Left, (e == 7));
        end
        check("t4_count", move_count, 32'd7);

        // Down held; enable low 10..19, then high again with Down still held
        key_n = 4'b1011;
        for (int e = 0; e <= 40; e++) begin
            if (e == 10) enable = 1'b0;
            if (e == 20) enable = 1'b1;
            step();
            check($sformatf("t5_down_e%0d", e), Down, (e == 7));
        end
        key_n = 4'hF;
        repeat (15) step();
        key_n = 4'b1011;
        for (int e = 0; e <= 7; e++) begin
            step();
            check($sformatf("t5_repress_e%0d", e), Down, (e == 7));
        end
        check("t5_count", move_count, 32'd8);

        // Asynchronous reset between edges while a pulse is high
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {28'd0, Right, Up, Down, Left}, 32'd0);
        check("async_reset_count", move_count, 32'd0);
        key_n = 4'hF;
        @(posedge clk);
        #2 reset = 1'b0;
        p0 = pulses;
        repeat (50) step();
        check("post_reset_pulses", pulses - p0, 32'd0);

        // 256 separate Right presses: one pulse each, count wraps to 0
        for (int p = 0; p < 256; p++) begin
            p0 = pulses;
            key_n = 4'b1110;
            repeat (6) step();
            key_n = 4'hF;
            repeat (14) step();
            check($sformatf("t6_single_p%0d", p), pulses - p0, 32'd1);
            if (p == 254) check("t6_count_255", move_count, 32'd255);
        end
        check("t6_count_wrap", move_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
